// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with one output pipeline register
// Decodes format, immediate and legality, captures rs1/rs2 data, valid/ready handshake both sides.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_pc,
  output logic [6:0]      de_opcode,
  output logic [2:0]      de_funct3,
  output logic [6:0]      de_funct7,
  output logic [4:0]      de_rd,
  output logic            de_rd_we,
  output logic [XLEN-1:0] de_rs1_data,
  output logic [XLEN-1:0] de_rs2_data,
  output logic [XLEN-1:0] de_imm,
  output logic [2:0]      de_fmt,
  output logic            de_illegal
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic            w_legal;
  logic            w_no_rd;
  logic [2:0]      w_fmt_raw;
  logic [2:0]      w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_rd_we;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_fmt;
  logic            r_illegal;

  assign w_opcode    = if_instr[6:0];
  assign w_funct3    = if_instr[14:12];
  assign w_funct7    = if_instr[31:25];
  assign w_rd        = if_instr[11:7];
  assign rf_rs1_addr = if_instr[19:15];
  assign rf_rs2_addr = if_instr[24:20];

  // Opcode classification and per-opcode funct legality.
  always_comb begin
    w_legal   = 1'b1;
    w_no_rd   = 1'b0;
    w_fmt_raw = FMT_R;
    case (w_opcode)
      OP_OP: begin
        w_fmt_raw = FMT_R;
        w_legal   = (w_funct7 == 7'b0000000) ||
                    ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      OP_IMM: begin
        w_fmt_raw = FMT_I;
        if (w_funct3 == 3'b001)
          w_legal = (w_funct7 == 7'b0000000);
        else if (w_funct3 == 3'b101)
          w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
      end
      OP_LOAD: begin
        w_fmt_raw = FMT_I;
        w_legal   = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
      end
      OP_JALR: begin
        w_fmt_raw = FMT_I;
        w_legal   = (w_funct3 == 3'b000);
      end
      OP_FENCE, OP_SYSTEM: begin
        w_fmt_raw = FMT_I;
        w_no_rd   = 1'b1;
      end
      OP_STORE: begin
        w_fmt_raw = FMT_S;
        w_no_rd   = 1'b1;
        w_legal   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
      end
      OP_BRANCH: begin
        w_fmt_raw = FMT_B;
        w_no_rd   = 1'b1;
        w_legal   = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
      end
      OP_LUI, OP_AUIPC: w_fmt_raw = FMT_U;
      OP_JAL:           w_fmt_raw = FMT_J;
      default:          w_legal   = 1'b0;
    endcase
    if (if_instr[1:0] != 2'b11)
      w_legal = 1'b0;
  end

  // Illegal encodings collapse to R format with a zero immediate.
  always_comb begin
    w_fmt = w_legal ? w_fmt_raw : FMT_R;
    w_imm = '0;
    case (w_fmt)
      FMT_I: w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      FMT_S: w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      FMT_B: w_imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
      FMT_U: w_imm = {if_instr[31:12], 12'b0};
      FMT_J: w_imm = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
    w_rd_we = w_legal && !w_no_rd && (w_rd != 5'd0);
  end

  assign if_ready = !flush && (!r_valid || de_ready);
  assign w_accept = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_fmt      <= '0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= if_pc;
      r_opcode   <= w_opcode;
      r_funct3   <= w_funct3;
      r_funct7   <= w_funct7;
      r_rd       <= w_rd;
      r_rd_we    <= w_rd_we;
      r_rs1_data <= rf_rs1_data;
      r_rs2_data <= rf_rs2_data;
      r_imm      <= w_imm;
      r_fmt      <= w_fmt;
      r_illegal  <= !w_legal;
    end else if (de_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign de_valid    = r_valid;
  assign de_pc       = r_pc;
  assign de_opcode   = r_opcode;
  assign de_funct3   = r_funct3;
  assign de_funct7   = r_funct7;
  assign de_rd       = r_rd;
  assign de_rd_we    = r_rd_we;
  assign de_rs1_data = r_rs1_data;
  assign de_rs2_data = r_rs2_data;
  assign de_imm      = r_imm;
  assign de_fmt      = r_fmt;
  assign de_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_pc;
  logic [6:0]  de_opcode;
  logic [2:0]  de_funct3;
  logic [6:0]  de_funct7;
  logic [4:0]  de_rd;
  logic        de_rd_we;
  logic [31:0] de_rs1_data;
  logic [31:0] de_rs2_data;
  logic [31:0] de_imm;
  logic [2:0]  de_fmt;
  logic        de_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc),
    .de_opcode(de_opcode), .de_funct3(de_funct3), .de_funct7(de_funct7),
    .de_rd(de_rd), .de_rd_we(de_rd_we),
    .de_rs1_data(de_rs1_data), .de_rs2_data(de_rs2_data),
    .de_imm(de_imm), .de_fmt(de_fmt), .de_illegal(de_illegal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; de_ready = 1'b0;
    tick; tick;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", de_valid); end
    checks++; if (de_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", de_pc); end
    checks++; if (de_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp 0", de_imm); end
    checks++; if (de_rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got %h exp 0", de_rd_we); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %h exp 1", if_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    if_valid = 1'b1; if_instr = 32'hFFF00093; if_pc = 32'h40; de_ready = 1'b1;
    tick;
    if_valid = 1'b0;
    checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %h exp 1", de_valid); end
    checks++; if (de_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", de_imm); end
    checks++; if (de_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d exp 1", de_rd); end
    checks++; if (de_fmt !== 3'd1) begin errors++; $display("FAIL addi_fmt got %0d exp 1", de_fmt); end
    checks++; if (de_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rd_we got %h exp 1", de_rd_we); end
    checks++; if (de_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got %h exp 0", de_illegal); end
    checks++; if (de_pc !== 32'h40) begin errors++; $display("FAIL addi_pc got %h exp 40", de_pc); end
    tick;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %h exp 0", de_valid); end
  endtask

  task automatic test_branch;
    if_valid = 1'b1; if_instr = 32'hFE208EE3; if_pc = 32'h80;
    rf_rs1_data = 32'd5; rf_rs2_data = 32'd7;
    #1;
    checks++; if (rf_rs1_addr !== 5'd1) begin errors++; $display("FAIL beq_rs1_addr got %0d exp 1", rf_rs1_addr); end
    checks++; if (rf_rs2_addr !== 5'd2) begin errors++; $display("FAIL beq_rs2_addr got %0d exp 2", rf_rs2_addr); end
    tick;
    if_valid = 1'b0; rf_rs1_data = '0; rf_rs2_data = '0;
    checks++; if (de_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h exp fffffffc", de_imm); end
    checks++; if (de_fmt !== 3'd3) begin errors++; $display("FAIL beq_fmt got %0d exp 3", de_fmt); end
    checks++; if (de_rd_we !== 1'b0) begin errors++; $display("FAIL beq_rd_we got %h exp 0", de_rd_we); end
    checks++; if (de_rs1_data !== 32'd5) begin errors++; $display("FAIL beq_rs1_data got %h exp 5", de_rs1_data); end
    checks++; if (de_rs2_data !== 32'd7) begin errors++; $display("FAIL beq_rs2_data got %h exp 7", de_rs2_data); end
    checks++; if (de_funct3 !== 3'd0) begin errors++; $display("FAIL beq_funct3 got %0d exp 0", de_funct3); end
    tick;
  endtask

  task automatic test_decode_table;
    logic [31:0] t_instr [14];
    logic [31:0] t_imm   [14];
    logic [2:0]  t_fmt   [14];
    logic [4:0]  t_rd    [14];
    logic        t_we    [14];
    logic        t_ill   [14];
    t_instr = '{32'h123452B7, 32'h00000000, 32'h0020A423, 32'hFF9FF0EF, 32'h402081B3,
                32'h40001033, 32'h00002063, 32'h40001013, 32'h4030D093, 32'h000010F3,
                32'h00003003, 32'h000010E7, 32'h00001017, 32'h0FF0000F};
    t_imm   = '{32'h12345000, 32'h0, 32'h8, 32'hFFFFFFF8, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h403, 32'h0,
                32'h0, 32'h0, 32'h1000, 32'hFF};
    t_fmt   = '{3'd4, 3'd0, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd4, 3'd1};
    t_rd    = '{5'd5, 5'd0, 5'd8, 5'd1, 5'd3, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0};
    t_we    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t_ill   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    de_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if_valid = 1'b1; if_instr = t_instr[i]; if_pc = 32'h1000 + 32'(i * 4);
      tick;
      checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL tbl%0d_valid got %h exp 1", i, de_valid); end
      checks++; if (de_imm !== t_imm[i]) begin errors++; $display("FAIL tbl%0d_imm got %h exp %h", i, de_imm, t_imm[i]); end
      checks++; if (de_fmt !== t_fmt[i]) begin errors++; $display("FAIL tbl%0d_fmt got %0d exp %0d", i, de_fmt, t_fmt[i]); end
      checks++; if (de_rd !== t_rd[i]) begin errors++; $display("FAIL tbl%0d_rd got %0d exp %0d", i, de_rd, t_rd[i]); end
      checks++; if (de_rd_we !== t_we[i]) begin errors++; $display("FAIL tbl%0d_rd_we got %h exp %h", i, de_rd_we, t_we[i]); end
      checks++; if (de_illegal !== t_ill[i]) begin errors++; $display("FAIL tbl%0d_illegal got %h exp %h", i, de_illegal, t_ill[i]); end
    end
    if_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    if_valid = 1'b1; if_instr = 32'h00100093; if_pc = 32'h100; de_ready = 1'b1;
    tick;
    de_ready = 1'b0; if_instr = 32'h00200113; if_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_if_ready got %h exp 0", i, if_ready); end
      tick;
      checks++; if (de_pc !== 32'h100 || de_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_hold got pc %h v %h exp pc 100 v 1", i, de_pc, de_valid); end
      checks++; if (de_imm !== 32'h1) begin errors++; $display("FAIL bp%0d_imm got %h exp 1", i, de_imm); end
    end
    de_ready = 1'b1;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %h exp 1", if_ready); end
    tick;
    if_valid = 1'b0;
    checks++; if (de_pc !== 32'h104 || de_imm !== 32'h2 || de_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next got pc %h imm %h v %h exp pc 104 imm 2 v 1", de_pc, de_imm, de_valid); end
    tick;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %h exp 0", de_valid); end
  endtask

  task automatic test_back_to_back;
    de_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_valid = 1'b1;
      if_instr = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
      if_pc = 32'(i * 4);
      tick;
      checks++; if (de_valid !== 1'b1 || de_pc !== 32'(i * 4) || de_imm !== 32'(i + 1)) begin
        errors++; $display("FAIL b2b%0d got v %h pc %h imm %h exp v 1 pc %h imm %h", i, de_valid, de_pc, de_imm, i * 4, i + 1); end
    end
    if_valid = 1'b0;
    tick;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %h exp 0", de_valid); end
  endtask

  task automatic test_flush;
    de_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00300193; if_pc = 32'h200;
    tick;
    checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got %h exp 1", de_valid); end
    flush = 1'b1; de_ready = 1'b1; if_instr = 32'h00400213; if_pc = 32'h204;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_if_ready got %h exp 0", if_ready); end
    tick;
    flush = 1'b0; if_valid = 1'b0;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %h exp 0", de_valid); end
    tick;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %h exp 0", de_valid); end
  endtask

  task automatic test_async_reset;
    de_ready = 1'b0; if_valid = 1'b1; if_instr = 32'hFFF00093; if_pc = 32'h300;
    tick;
    if_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %h exp 0", de_valid); end
    checks++; if (de_imm !== 32'h0 || de_pc !== 32'h0) begin errors++; $display("FAIL arst_data got imm %h pc %h exp 0 0", de_imm, de_pc); end
    #1;
    rst_n = 1'b1;
    if_valid = 1'b1; if_instr = 32'h00200113; if_pc = 32'h304;
    tick;
    if_valid = 1'b0;
    checks++; if (de_valid !== 1'b1 || de_rd !== 5'd2 || de_pc !== 32'h304) begin
      errors++; $display("FAIL arst_first got v %h rd %0d pc %h exp v 1 rd 2 pc 304", de_valid, de_rd, de_pc); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_branch;
    test_decode_table;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
